// File: rtl/oscope_pkg.sv
// rtl/oscope_pkg.sv - shared types and widths for the oscilloscope capture path
package oscope_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PRIME = 2'd1,
        DRAIN = 2'd2
    } buf_state_t;

    localparam int SAMPLE_W = 8;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchronizer with a registered rising-edge strobe
module sync_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic level_o,
    output logic strobe_o
);

    logic [2:0] sync_q;
    logic       strobe_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], async_i};
            // sync_q[2] is the previous synced level, so this fires once per rise
            strobe_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign level_o  = sync_q[1];
    assign strobe_o = strobe_q;

endmodule

// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - single-bank sample store drained serially to the Pi link
module capture_buffer
    import oscope_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = 16
) (
    input  logic              osc_clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              pi_clk,
    output logic              pi_data,
    output logic              pi_signal_flag,
    output logic [CNT_W-1:0]  overrun_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BIT_W  = $clog2(DATA_W);

    logic s_edge, p_edge, s_level, p_level;
    logic unused_levels;

    sync_edge u_sample_sync (
        .clk_i    (osc_clk),
        .reset_i  (reset),
        .async_i  (sample_valid),
        .level_o  (s_level),
        .strobe_o (s_edge)
    );

    sync_edge u_pi_sync (
        .clk_i    (osc_clk),
        .reset_i  (reset),
        .async_i  (pi_clk),
        .level_o  (p_level),
        .strobe_o (p_edge)
    );

    assign unused_levels = s_level ^ p_level;

    // Three stages so the byte lines up with the strobe, which is three edges late.
    logic [DATA_W-1:0] d1_q, d2_q, d3_q;
    always_ff @(posedge osc_clk) begin
        d1_q <= sample_data;
        d2_q <= d1_q;
        d3_q <= d2_q;
    end

    buf_state_t        state_q;
    logic              prime_q;
    logic              pf_load_q;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, raddr;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shift_q, prefetch_q, rdata_q;
    logic              pi_data_q, flag_q;
    logic [CNT_W-1:0]  ovr_q;
    logic              wr_en;

    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_en = (state_q == FILL) && s_edge;

    always_comb begin
        raddr = rd_ptr_q + ADDR_W'(2);
        if (state_q == PRIME) begin
            raddr = prime_q ? ADDR_W'(1) : '0;
        end
    end

    always_ff @(posedge osc_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= d3_q;
        end
        rdata_q <= mem[raddr];
    end

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state_q    <= FILL;
            prime_q    <= 1'b0;
            pf_load_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            prefetch_q <= '0;
            pi_data_q  <= 1'b0;
            flag_q     <= 1'b0;
            ovr_q      <= '0;
        end else begin
            pf_load_q <= 1'b0;
            if (pf_load_q) begin
                prefetch_q <= rdata_q;
            end
            if (s_edge && state_q != FILL && ovr_q != '1) begin
                ovr_q <= ovr_q + CNT_W'(1);
            end
            case (state_q)
                FILL: begin
                    pi_data_q <= 1'b0;
                    flag_q    <= 1'b0;
                    if (s_edge) begin
                        if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                            wr_ptr_q <= '0;
                            prime_q  <= 1'b0;
                            state_q  <= PRIME;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                        end
                    end
                end
                PRIME: begin
                    if (!prime_q) begin
                        prime_q <= 1'b1;
                    end else begin
                        shift_q   <= rdata_q;
                        pf_load_q <= 1'b1;
                        bit_cnt_q <= '0;
                        rd_ptr_q  <= '0;
                        pi_data_q <= rdata_q[DATA_W-1];
                        flag_q    <= 1'b1;
                        state_q   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (p_edge) begin
                        if (bit_cnt_q != BIT_W'(DATA_W - 1)) begin
                            shift_q   <= shift_q << 1;
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            pi_data_q <= shift_q[DATA_W-2];
                        end else if (rd_ptr_q == ADDR_W'(DEPTH - 1)) begin
                            rd_ptr_q  <= '0;
                            bit_cnt_q <= '0;
                            pi_data_q <= 1'b0;
                            flag_q    <= 1'b0;
                            state_q   <= FILL;
                        end else begin
                            shift_q   <= prefetch_q;
                            bit_cnt_q <= '0;
                            rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
                            pf_load_q <= 1'b1;
                            pi_data_q <= prefetch_q[DATA_W-1];
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign pi_data        = pi_data_q;
    assign pi_signal_flag = flag_q;
    assign overrun_count  = ovr_q;

endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - scoreboard bench for capture_buffer with DEPTH=4
module tb_capture_buffer;

    localparam int DW    = 8;
    localparam int DEP   = 4;
    localparam int CW    = 16;
    localparam int NBITS = DEP * DW;

    logic          osc_clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          pi_clk = 1'b0;
    logic          pi_data;
    logic          pi_signal_flag;
    logic [CW-1:0] overrun_count;

    capture_buffer #(.DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) dut (
        .osc_clk        (osc_clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .pi_clk         (pi_clk),
        .pi_data        (pi_data),
        .pi_signal_flag (pi_signal_flag),
        .overrun_count  (overrun_count)
    );

    always #5 osc_clk = ~osc_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic          exp_q[$];
    logic [DW-1:0] model_mem [DEP];
    int            model_fill = 0;
    bit            model_draining = 0;
    int            model_drained = 0;
    int            model_ovr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge pi_clk) begin
        if (exp_q.size() > 0) begin
            check("pi_data_bit", 32'(pi_data), 32'(exp_q.pop_front()));
            check("flag_during_drain", 32'(pi_signal_flag), 32'd1);
        end else begin
            check("flag_idle", 32'(pi_signal_flag), 32'd0);
            check("pi_data_idle", 32'(pi_data), 32'd0);
        end
    end

    // Reference: a sample is stored only while no readout is pending; a full bank is queued MSB first.
    function automatic bit model_sample(input logic [DW-1:0] d);
        if (model_draining) begin
            if (model_ovr < (1 << CW) - 1) model_ovr++;
            return 1'b0;
        end
        model_mem[model_fill] = d;
        model_fill++;
        if (model_fill == DEP) begin
            for (int b = 0; b < DEP; b++)
                for (int k = DW - 1; k >= 0; k--) exp_q.push_back(model_mem[b][k]);
            model_fill     = 0;
            model_draining = 1;
            model_drained  = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic send_sample(input logic [DW-1:0] d, input int hold);
        bit was_draining;
        bit completes;
        int rise;
        was_draining = model_draining;
        completes = model_sample(d);
        rise = -1;
        @(negedge osc_clk);
        sample_valid = 1'b1;
        sample_data  = d;
        for (int i = 1; i <= hold; i++) begin
            @(negedge osc_clk);
            if (rise < 0 && pi_signal_flag) rise = i;
        end
        sample_valid = 1'b0;
        repeat (4) @(negedge osc_clk);
        if (completes) begin
            check("flag_rise_within_6", 32'(rise >= 1 && rise <= 6), 32'd1);
            check("first_bit_after_fill", 32'(pi_data), 32'(model_mem[0][DW-1]));
        end else if (!was_draining) begin
            check("flag_stays_low_in_fill", 32'(rise), 32'hffff_ffff);
        end
    endtask

    task automatic pi_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge osc_clk);
            pi_clk = 1'b1;
            if (model_draining) begin
                model_drained++;
                if (model_drained == NBITS) model_draining = 0;
            end
            repeat (5) @(negedge osc_clk);
            pi_clk = 1'b0;
            repeat (5) @(negedge osc_clk);
        end
    endtask

    task automatic fill_fixed(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] c, input logic [DW-1:0] d);
        send_sample(a, 4);
        send_sample(b, 4);
        send_sample(c, 4);
        send_sample(d, 8);
    endtask

    initial begin
        // 1: reset state
        reset = 1'b1;
        repeat (2) @(negedge osc_clk);
        reset = 1'b0;
        repeat (20) @(negedge osc_clk);
        check("reset_flag", 32'(pi_signal_flag), 32'd0);
        check("reset_pi_data", 32'(pi_data), 32'd0);
        check("reset_overrun", 32'(overrun_count), 32'd0);

        // 2-3: fixed fill, full readout, refill
        fill_fixed(8'hA5, 8'h3C, 8'hFF, 8'h01);
        check("pi_data_msb_a5", 32'(pi_data), 32'd1);
        pi_pulses(NBITS);
        check("flag_low_after_drain", 32'(pi_signal_flag), 32'd0);
        fill_fixed(8'h10, 8'h11, 8'h12, 8'h13);
        pi_pulses(NBITS);

        // 4: overruns during readout
        fill_fixed(8'hA5, 8'h3C, 8'hFF, 8'h01);
        for (int i = 0; i < 3; i++) begin
            pi_pulses(8);
            send_sample(8'(8'hE0 + i), 4);
        end
        pi_pulses(8);
        check("overrun_three", 32'(overrun_count), 32'(model_ovr));
        check("flag_low_after_overrun_drain", 32'(pi_signal_flag), 32'd0);

        // random passes with random overrun injections
        for (int p = 0; p < 3; p++) begin
            int left;
            for (int s = 0; s < DEP; s++) send_sample(8'($urandom), (s == DEP - 1) ? 8 : 4);
            left = NBITS;
            while (left > 0) begin
                int n;
                n = int'($urandom_range(1, 12));
                if (n > left) n = left;
                pi_pulses(n);
                left -= n;
                if (left > 0 && $urandom_range(0, 2) == 0) send_sample(8'($urandom), 4);
            end
            check("overrun_random", 32'(overrun_count), 32'(model_ovr));
        end

        // 5: reset mid-readout
        for (int s = 0; s < DEP; s++) send_sample(8'($urandom), (s == DEP - 1) ? 8 : 4);
        pi_pulses(10);
        @(negedge osc_clk);
        reset = 1'b1;
        @(negedge osc_clk);
        reset = 1'b0;
        check("flag_after_reset", 32'(pi_signal_flag), 32'd0);
        check("overrun_after_reset", 32'(overrun_count), 32'd0);
        exp_q.delete();
        model_fill = 0;
        model_draining = 0;
        model_ovr = 0;
        fill_fixed(8'h5A, 8'hC3, 8'h00, 8'h7E);
        pi_pulses(NBITS);

        // 6: long sample_valid stores one byte; pi_clk ignored in FILL
        void'(model_sample(8'h96));
        fork
            begin
                @(negedge osc_clk);
                sample_valid = 1'b1;
                sample_data  = 8'h96;
                repeat (1000) @(negedge osc_clk);
                sample_valid = 1'b0;
            end
            pi_pulses(20);
        join
        repeat (6) @(negedge osc_clk);
        check("flag_low_after_long_hold", 32'(pi_signal_flag), 32'd0);
        pi_pulses(3);
        send_sample(8'h21, 4);
        send_sample(8'h42, 4);
        send_sample(8'h84, 8);
        pi_pulses(NBITS);
        check("flag_low_final", 32'(pi_signal_flag), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
